regfile_bypass_mp: RTL and testbench

//  MIPS GPR file, next generation: parametrised width/depth, NUM_RD read ports,

---
 rtl/regfile_bypass_mp.sv | 86 ++++++++
 tb/tb_regfile_bypass_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_mp.sv
// rtl/regfile_bypass_mp.sv - MIPS GPR file with ALU/memory/link write ports, byte-merged loads,
// write-to-read bypass and a pending-load scoreboard.
module regfile_bypass_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int LINK_REG = 31,
   parameter int V0_REG   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wm_en,
   input  logic [ADDR_W-1:0]        wm_addr,
   input  logic [DATA_W-1:0]        wm_data,
   input  logic [DATA_W/8-1:0]      wm_byteen,
   input  logic                     link_en,
   input  logic [DATA_W-1:0]        link_data,
   input  logic                     busy_set,
   input  logic [ADDR_W-1:0]        busy_addr,
   output logic [DATA_W-1:0]        dbg_v0
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [DATA_W-1:0] w_nv   [DEPTH];

   // Next value per register: ALU, then byte-merged load, then link on top.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         w_nv[r] = r_regs[r];
         if (wa_en && wa_addr == ADDR_W'(r))
            w_nv[r] = wa_data;
         if (wm_en && wm_addr == ADDR_W'(r)) begin
            for (int b = 0; b < NB; b++) begin
               if (wm_byteen[b])
                  w_nv[r][b*8 +: 8] = wm_data[b*8 +: 8];
            end
         end
         if (link_en && r == LINK_REG)
            w_nv[r] = link_data;
         if (r == 0)
            w_nv[r] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++)
            r_regs[r] <= '0;
         r_busy <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++)
            r_regs[r] <= w_nv[r];
         r_busy[0] <= 1'b0;
         for (int r = 1; r < DEPTH; r++) begin
            if (busy_set && busy_addr == ADDR_W'(r))
               r_busy[r] <= 1'b1;
            else if (wm_en && wm_addr == ADDR_W'(r))
               r_busy[r] <= 1'b0;
         end
      end
   end

   // A load completing this cycle is forwarded, so it must not report busy.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         logic [ADDR_W-1:0] w_a;
         w_a = rd_addr[i*ADDR_W +: ADDR_W];
         rd_data[i*DATA_W +: DATA_W] = reset ? '0 : w_nv[w_a];
         rd_busy[i] = r_busy[w_a] & ~(wm_en && wm_addr == w_a) & ~reset
                      & (w_a != '0);
      end
   end

   assign dbg_v0 = reset ? '0 : r_regs[V0_REG];

endmodule

// File: tb/tb_regfile_bypass_mp.sv
// tb/tb_regfile_bypass_mp.sv - scoreboard bench for regfile_bypass_mp.
module tb_regfile_bypass_mp;
   logic        clk;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wa_en;
   logic [4:0]  wa_addr;
   logic [31:0] wa_data;
   logic        wm_en;
   logic [4:0]  wm_addr;
   logic [31:0] wm_data;
   logic [3:0]  wm_byteen;
   logic        link_en;
   logic [31:0] link_data;
   logic        busy_set;
   logic [4:0]  busy_addr;
   logic [31:0] dbg_v0;

   regfile_bypass_mp dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wm_en(wm_en), .wm_addr(wm_addr), .wm_data(wm_data),
      .wm_byteen(wm_byteen), .link_en(link_en), .link_data(link_data),
      .busy_set(busy_set), .busy_addr(busy_addr), .dbg_v0(dbg_v0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_regs [32];
   logic [31:0] m_busy;

   bit          dir0_en, dir1_en, dirb_en, dirv_en;
   logic [31:0] dir0, dir1, dirv;
   logic [1:0]  dirb;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mnv(input int r);
      logic [31:0] v;
      v = m_regs[r];
      if (wa_en && wa_addr == r) v = wa_data;
      if (wm_en && wm_addr == r)
         for (int b = 0; b < 4; b++)
            if (wm_byteen[b]) v[b*8 +: 8] = wm_data[b*8 +: 8];
      if (link_en && r == 31) v = link_data;
      if (r == 0) v = 32'h0;
      return v;
   endfunction

   function automatic logic mbusy(input logic [4:0] a);
      if (reset || a == 5'd0) return 1'b0;
      return m_busy[a] && !(wm_en && wm_addr == a);
   endfunction

   task automatic clear_inputs();
      wa_en = 0; wa_addr = 0; wa_data = 0;
      wm_en = 0; wm_addr = 0; wm_data = 0; wm_byteen = 0;
      link_en = 0; link_data = 0; busy_set = 0; busy_addr = 0;
      dir0_en = 0; dir1_en = 0; dirb_en = 0; dirv_en = 0;
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic step(input string name);
      logic [4:0] a0, a1;
      logic [31:0] tmp;
      a0 = rd_addr[4:0];
      a1 = rd_addr[9:5];
      sb.push_back('{tag: {name, "_rd0"}, sel: 0, exp: reset ? 32'h0 : mnv(a0)});
      sb.push_back('{tag: {name, "_rd1"}, sel: 1, exp: reset ? 32'h0 : mnv(a1)});
      sb.push_back('{tag: {name, "_busy"}, sel: 2, exp: {30'h0, mbusy(a1), mbusy(a0)}});
      sb.push_back('{tag: {name, "_v0"}, sel: 3, exp: reset ? 32'h0 : m_regs[2]});
      if (dir0_en) sb.push_back('{tag: {name, "_dir_rd0"}, sel: 0, exp: dir0});
      if (dir1_en) sb.push_back('{tag: {name, "_dir_rd1"}, sel: 1, exp: dir1});
      if (dirb_en) sb.push_back('{tag: {name, "_dir_busy"}, sel: 2, exp: {30'h0, dirb}});
      if (dirv_en) sb.push_back('{tag: {name, "_dir_v0"}, sel: 3, exp: dirv});
      #2;
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         case (e.sel)
            0: tmp = rd_data[31:0];
            1: tmp = rd_data[63:32];
            2: tmp = {30'h0, rd_busy};
            default: tmp = dbg_v0;
         endcase
         check(e.tag, tmp, e.exp);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
         m_busy = 32'h0;
      end else begin
         logic [31:0] nv [32];
         for (int r = 0; r < 32; r++) nv[r] = mnv(r);
         for (int r = 0; r < 32; r++) m_regs[r] = nv[r];
         for (int r = 1; r < 32; r++) begin
            if (busy_set && busy_addr == r) m_busy[r] = 1'b1;
            else if (wm_en && wm_addr == r) m_busy[r] = 1'b0;
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
      m_busy = 32'h0;
      clear_inputs();
      reset = 1; rd_addr = 0;
      @(negedge clk);
      step("rst0");
      rd_addr = {5'd2, 5'd5};
      wa_en = 1; wa_addr = 5'd2; wa_data = 32'h2A;
      dirv_en = 1; dirv = 32'h0;
      step("rst_wr");
      reset = 0;

      wa_en = 1; wa_addr = 5'd5; wa_data = 32'h1234_5678;
      rd_addr = {5'd2, 5'd5}; dir0_en = 1; dir0 = 32'h1234_5678;
      dir1_en = 1; dir1 = 32'h0;
      step("t1_bypass");
      rd_addr = {5'd0, 5'd5}; dir0_en = 1; dir0 = 32'h1234_5678;
      dirv_en = 1; dirv = 32'h0;
      step("t1_read");

      wa_en = 1; wa_addr = 5'd8; wa_data = 32'hAABB_CCDD;
      step("t2_init");
      wm_en = 1; wm_addr = 5'd8; wm_data = 32'h0000_1100; wm_byteen = 4'b0010;
      rd_addr = {5'd0, 5'd8}; dir0_en = 1; dir0 = 32'hAABB_11DD;
      step("t2_lane");
      wm_en = 1; wm_addr = 5'd8; wm_data = 32'hFFFF_FFFF; wm_byteen = 4'b0000;
      rd_addr = {5'd0, 5'd8}; dir0_en = 1; dir0 = 32'hAABB_11DD;
      step("t2_nolane");

      wa_en = 1; wa_addr = 5'd31; wa_data = 32'h1;
      wm_en = 1; wm_addr = 5'd31; wm_data = 32'h2; wm_byteen = 4'hF;
      link_en = 1; link_data = 32'h3;
      rd_addr = {5'd31, 5'd31}; dir0_en = 1; dir0 = 32'h3;
      step("t3_prio");
      wa_en = 1; wa_addr = 5'd4; wa_data = 32'h7;
      wm_en = 1; wm_addr = 5'd9; wm_data = 32'h9; wm_byteen = 4'hF;
      step("t3_multi");
      rd_addr = {5'd9, 5'd4}; dir0_en = 1; dir0 = 32'h7; dir1_en = 1; dir1 = 32'h9;
      step("t3_read");

      wa_en = 1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
      wm_en = 1; wm_addr = 5'd0; wm_data = 32'hFFFF_FFFF; wm_byteen = 4'hF;
      busy_set = 1; busy_addr = 5'd0;
      rd_addr = {5'd0, 5'd0}; dir0_en = 1; dir0 = 32'h0;
      step("t4_wr0");
      rd_addr = {5'd0, 5'd0}; dir0_en = 1; dir0 = 32'h0; dirb_en = 1; dirb = 2'b00;
      step("t4_rd0");

      busy_set = 1; busy_addr = 5'd3;
      step("t5_set");
      rd_addr = {5'd0, 5'd3}; dirb_en = 1; dirb = 2'b01;
      step("t5_busy");
      wm_en = 1; wm_addr = 5'd3; wm_data = 32'hCAFE_0055; wm_byteen = 4'hF;
      rd_addr = {5'd0, 5'd3}; dirb_en = 1; dirb = 2'b00;
      dir0_en = 1; dir0 = 32'hCAFE_0055;
      step("t5_done");
      busy_set = 1; busy_addr = 5'd3;
      wm_en = 1; wm_addr = 5'd3; wm_data = 32'h1; wm_byteen = 4'hF;
      step("t5_setclr");
      rd_addr = {5'd3, 5'd3}; dirb_en = 1; dirb = 2'b11;
      step("t5_setwins");

      reset = 1;
      wa_en = 1; wa_addr = 5'd2; wa_data = 32'h2A;
      rd_addr = {5'd3, 5'd2}; dir0_en = 1; dir0 = 32'h0; dirb_en = 1; dirb = 2'b00;
      step("t6_rst");
      reset = 0;
      rd_addr = {5'd3, 5'd2}; dir0_en = 1; dir0 = 32'h0; dirv_en = 1; dirv = 32'h0;
      step("t6_clr");
      wa_en = 1; wa_addr = 5'd2; wa_data = 32'h2A; dirv_en = 1; dirv = 32'h0;
      step("t6_wr");
      dirv_en = 1; dirv = 32'h2A;
      step("t6_v0");

      for (int n = 0; n < 300; n++) begin
         reset     = ($urandom_range(0, 49) == 0);
         wa_en     = $urandom_range(0, 1);
         wa_addr   = 5'($urandom_range(0, 7));
         wa_data   = $urandom;
         wm_en     = $urandom_range(0, 1);
         wm_addr   = 5'($urandom_range(0, 7));
         wm_data   = $urandom;
         wm_byteen = 4'($urandom_range(0, 15));
         link_en   = ($urandom_range(0, 3) == 0);
         link_data = $urandom;
         busy_set  = $urandom_range(0, 1);
         busy_addr = 5'($urandom_range(0, 7));
         rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         if ($urandom_range(0, 7) == 0) rd_addr[4:0] = 5'd31;
         step("rand");
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
